mood_step_ctrl: RTL and testbench

Input-conditioning and step-scheduling controller that sits in front of the RGB mode selector. It synchronizes and debounces the raw push-buttons and channel switches. It arbitrates between manual button presses and an internal auto-demo scheduler, and drives the selector's step inputs (`pb_up`/`pb_down`, one-cycle pulses) together with a channel mask (`sw_r/g/b`) that is valid in the same cycle.

---
 rtl/mood_step_ctrl.sv | 151 +++++++++++++++
 tb/tb_mood_step_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mood_step_ctrl.sv
// Button/switch conditioning and step scheduler in front of the RGB mode selector.
// Merges manual presses with an auto-demo ticker into one-cycle pb_up/pb_down pulses plus a channel mask.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_MANUAL | steps come only from the up/down buttons, mask follows switches
//   S_AUTO   | period counter ticks pb_up with a rotating one-hot mask
module mood_step_ctrl #(
  parameter int DEB_CYCLES  = 500000,
  parameter int AUTO_PERIOD = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic btn_auto_raw,
  input  logic sw_r_raw,
  input  logic sw_g_raw,
  input  logic sw_b_raw,
  output logic pb_up,
  output logic pb_down,
  output logic sw_r,
  output logic sw_g,
  output logic sw_b,
  output logic auto_on
);

  localparam logic [CNT_W-1:0] L_DEB      = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] L_PER_LAST = CNT_W'(AUTO_PERIOD - 1);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } mode_t;

  // bit order: {sw_r, sw_g, sw_b, auto, down, up}
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;
  logic [2:0] w_btn_s;
  logic [2:0] w_sw_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {sw_r_raw, sw_g_raw, sw_b_raw, btn_auto_raw, btn_down_raw, btn_up_raw};
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2[2:0];
  assign w_sw_s  = r_sync2[5:3];

  logic [2:0]       r_stable;
  logic [2:0]       r_stable_d;
  logic [CNT_W-1:0] r_deb_cnt [3];
  logic [2:0]       w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < 3; i++) begin
        if (w_btn_s[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == L_DEB) begin
          r_stable[i]  <= ~r_stable[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + L_ONE;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  mode_t            r_mode;
  logic [CNT_W-1:0] r_per_cnt;
  logic             r_tick;
  logic [2:0]       r_ptr;
  logic             w_up;
  logic             w_dn;
  logic             w_man;
  logic             w_tog;
  logic             w_tick_go;
  logic             w_auto_nx;

  assign w_up      = w_press[0] & ~w_press[1];
  assign w_dn      = w_press[1] & ~w_press[0];
  assign w_man     = w_up | w_dn;
  assign w_tog     = w_press[2];
  assign w_tick_go = r_tick & (r_mode == S_AUTO) & ~w_tog & ~w_man;
  assign w_auto_nx = (r_mode == S_AUTO) ^ w_tog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= S_MANUAL;
      r_per_cnt <= '0;
      r_tick    <= 1'b0;
      r_ptr     <= '0;
      pb_up     <= 1'b0;
      pb_down   <= 1'b0;
      sw_r      <= 1'b0;
      sw_g      <= 1'b0;
      sw_b      <= 1'b0;
      auto_on   <= 1'b0;
    end else begin
      pb_up   <= w_up | w_tick_go;
      pb_down <= w_dn;
      auto_on <= w_auto_nx;
      if (w_man)          {sw_r, sw_g, sw_b} <= w_sw_s;
      else if (w_tick_go) {sw_r, sw_g, sw_b} <= r_ptr;
      else if (w_auto_nx) {sw_r, sw_g, sw_b} <= 3'b000;
      else                {sw_r, sw_g, sw_b} <= w_sw_s;
      r_tick <= 1'b0;
      case (r_mode)
        S_MANUAL: begin
          if (w_tog) begin
            r_mode    <= S_AUTO;
            r_ptr     <= 3'b100;
            r_per_cnt <= '0;
          end
        end
        S_AUTO: begin
          if (w_tog) begin
            r_mode    <= S_MANUAL;
            r_per_cnt <= '0;
          end else if (w_man) begin
            // the press cycle itself counts as slot 0 of the new period
            r_per_cnt <= L_ONE;
          end else if (r_per_cnt == L_PER_LAST) begin
            r_per_cnt <= '0;
            r_tick    <= 1'b1;
          end else begin
            r_per_cnt <= r_per_cnt + L_ONE;
          end
          if (w_tick_go) r_ptr <= {r_ptr[0], r_ptr[2:1]};
        end
        default: r_mode <= S_MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_mood_step_ctrl.sv
// Bench for mood_step_ctrl: directed scenarios with literal expectations plus random stimulus,
// all outputs compared every cycle against an event/timestamp-level model.
module tb_mood_step_ctrl;
  localparam int D = 4;
  localparam int P = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up_raw = 0, btn_down_raw = 0, btn_auto_raw = 0;
  logic sw_r_raw = 0, sw_g_raw = 0, sw_b_raw = 0;
  logic pb_up, pb_down, sw_r, sw_g, sw_b, auto_on;
  logic [2:0] mask;
  assign mask = {sw_r, sw_g, sw_b};

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mood_step_ctrl #(.DEB_CYCLES(D), .AUTO_PERIOD(P), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw), .btn_auto_raw(btn_auto_raw),
    .sw_r_raw(sw_r_raw), .sw_g_raw(sw_g_raw), .sw_b_raw(sw_b_raw),
    .pb_up(pb_up), .pb_down(pb_down), .sw_r(sw_r), .sw_g(sw_g), .sw_b(sw_b),
    .auto_on(auto_on)
  );

  // model: sync = raw seen two edges ago; a level is accepted after D+1 consecutive
  // differing samples; rising acceptance emits an event one edge later; auto ticks by timestamp
  logic [5:0] h1, h2, s;
  logic [2:0] m_stable, m_pend, ev;
  int         m_run [3];
  int         mcyc, m_next, m_ptr;
  bit         m_auto;
  bit         exp_up, exp_dn, exp_auto;
  logic [2:0] exp_mask;

  always @(posedge clk or negedge rst_n) begin
    bit up, dn, man, tog, tick;
    if (!rst_n) begin
      h1 = '0; h2 = '0; m_stable = '0; m_pend = '0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_auto = 0; m_ptr = 0; m_next = 0; mcyc = 0;
      exp_up = 0; exp_dn = 0; exp_auto = 0; exp_mask = '0;
    end else begin
      mcyc = mcyc + 1;
      s  = h2;
      h2 = h1;
      h1 = {sw_r_raw, sw_g_raw, sw_b_raw, btn_auto_raw, btn_down_raw, btn_up_raw};
      ev = m_pend;
      m_pend = '0;
      for (int b = 0; b < 3; b++) begin
        if (s[b] != m_stable[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == D + 1) begin
            m_stable[b] = ~m_stable[b];
            m_run[b] = 0;
            if (m_stable[b]) m_pend[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      up  = ev[0] && !ev[1];
      dn  = ev[1] && !ev[0];
      man = up || dn;
      tog = ev[2];
      tick = m_auto && !tog && !man && (mcyc == m_next);
      exp_up = up || tick;
      exp_dn = dn;
      if (man)       exp_mask = s[5:3];
      else if (tick) exp_mask = 3'b100 >> m_ptr;
      else if (m_auto != tog) exp_mask = 3'b000;
      else           exp_mask = s[5:3];
      if (m_auto && !tog && (tick || man)) m_next = mcyc + P;
      if (tick) m_ptr = (m_ptr + 1) % 3;
      if (tog) begin
        if (!m_auto) begin
          m_ptr = 0;
          m_next = mcyc + P + 1;
        end
        m_auto = !m_auto;
      end
      exp_auto = m_auto;
    end
  end

  always @(negedge clk) begin
    total = total + 4;
    if (pb_up !== exp_up) begin
      bad = bad + 1;
      $display("FAIL model pb_up @%0t: got %b want %b", $time, pb_up, exp_up);
    end
    if (pb_down !== exp_dn) begin
      bad = bad + 1;
      $display("FAIL model pb_down @%0t: got %b want %b", $time, pb_down, exp_dn);
    end
    if (mask !== exp_mask) begin
      bad = bad + 1;
      $display("FAIL model mask @%0t: got %b want %b", $time, mask, exp_mask);
    end
    if (auto_on !== exp_auto) begin
      bad = bad + 1;
      $display("FAIL model auto_on @%0t: got %b want %b", $time, auto_on, exp_auto);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic count_pulses(input int n, output int nu, output int nd);
    nu = 0; nd = 0;
    repeat (n) begin
      @(negedge clk);
      if (pb_up) nu++;
      if (pb_down) nd++;
    end
  endtask

  initial begin
    int k, a, b, nu, nd, nu2, nd2;
    int tmr [3];
    logic [2:0] lvl;
    #2;
    chk("reset_outs", {2'b0, pb_up, pb_down, mask, auto_on}, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // manual up with green switch
    @(negedge clk);
    sw_g_raw = 1'b1;
    repeat (4) @(negedge clk);
    btn_up_raw = 1'b1;
    k = cyc + 1;
    wait_edge(k + 6);
    chk("up_before", {7'b0, pb_up}, 8'h00);
    wait_edge(k + 7);
    chk("up_pulse", {7'b0, pb_up}, 8'h01);
    chk("up_mask", {5'b0, mask}, 8'h02);
    wait_edge(k + 8);
    chk("up_after", {7'b0, pb_up}, 8'h00);
    count_pulses(10, nu, nd);
    chk("up_held", nu[7:0], 8'h00);
    btn_up_raw = 1'b0;
    count_pulses(15, nu, nd);
    chk("up_release", nu[7:0], 8'h00);

    // glitch rejection, then a real down press
    btn_down_raw = 1'b1;
    repeat (3) @(negedge clk);
    btn_down_raw = 1'b0;
    count_pulses(15, nu, nd);
    chk("glitch_dn", nd[7:0], 8'h00);
    btn_down_raw = 1'b1;
    count_pulses(8, nu, nd);
    btn_down_raw = 1'b0;
    count_pulses(12, nu2, nd2);
    chk("held8_dn", 8'(nd + nd2), 8'h01);

    // auto sequence with switches 101
    sw_r_raw = 1'b1; sw_g_raw = 1'b0; sw_b_raw = 1'b1;
    repeat (5) @(negedge clk);
    btn_auto_raw = 1'b1;
    a = cyc + 1;
    wait_edge(a + 6);
    chk("auto_pre", {7'b0, auto_on}, 8'h00);
    wait_edge(a + 7);
    chk("auto_on", {7'b0, auto_on}, 8'h01);
    wait_edge(a + 8);
    btn_auto_raw = 1'b0;
    wait_edge(a + 17);
    chk("auto_nopulse", {7'b0, pb_up}, 8'h00);
    for (int j = 0; j < 4; j++) begin
      logic [2:0] m;
      m = (j == 1) ? 3'b010 : (j == 2) ? 3'b001 : 3'b100;
      wait_edge(a + 18 + 10 * j);
      chk("auto_tick", {7'b0, pb_up}, 8'h01);
      chk("auto_mask", {5'b0, mask}, {5'b0, m});
      wait_edge(a + 19 + 10 * j);
      chk("auto_idle", {4'b0, pb_up, mask}, 8'h00);
    end

    // down press landing on the tick at a+58
    wait_edge(a + 50);
    btn_down_raw = 1'b1;
    wait_edge(a + 58);
    chk("arb_dn", {6'b0, pb_up, pb_down}, 8'h01);
    chk("arb_mask", {5'b0, mask}, 8'h05);
    btn_down_raw = 1'b0;
    wait_edge(a + 67);
    chk("arb_gap", {6'b0, pb_up, pb_down}, 8'h00);
    wait_edge(a + 68);
    chk("arb_next", {7'b0, pb_up}, 8'h01);
    chk("arb_ptr", {5'b0, mask}, 8'h02);

    // leave auto mode
    btn_auto_raw = 1'b1;
    b = cyc + 1;
    wait_edge(b + 7);
    chk("auto_off", {7'b0, auto_on}, 8'h00);
    btn_auto_raw = 1'b0;
    count_pulses(25, nu, nd);
    chk("auto_stopped", nu[7:0], 8'h00);

    // simultaneous up and down, then each alone
    btn_up_raw = 1'b1; btn_down_raw = 1'b1;
    count_pulses(10, nu, nd);
    btn_up_raw = 1'b0; btn_down_raw = 1'b0;
    count_pulses(10, nu2, nd2);
    chk("both_none", 8'(nu + nd + nu2 + nd2), 8'h00);
    btn_up_raw = 1'b1;
    count_pulses(10, nu, nd);
    btn_up_raw = 1'b0;
    count_pulses(10, nu2, nd2);
    chk("alone_up", 8'(nu + nu2), 8'h01);
    chk("alone_up_dn", 8'(nd + nd2), 8'h00);
    btn_down_raw = 1'b1;
    count_pulses(10, nu, nd);
    btn_down_raw = 1'b0;
    count_pulses(10, nu2, nd2);
    chk("alone_dn", 8'(nd + nd2), 8'h01);

    // reset in the middle of auto mode and of a debounce
    btn_auto_raw = 1'b1;
    b = cyc + 1;
    wait_edge(b + 8);
    btn_auto_raw = 1'b0;
    chk("auto_again", {7'b0, auto_on}, 8'h01);
    wait_edge(b + 14);
    btn_up_raw = 1'b1;
    repeat (3) @(negedge clk);
    btn_up_raw = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset", {2'b0, pb_up, pb_down, mask, auto_on}, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    count_pulses(30, nu, nd);
    chk("post_reset_pulses", 8'(nu + nd), 8'h00);
    chk("post_reset_auto", {7'b0, auto_on}, 8'h00);

    // random stimulus, checked by the model every cycle
    for (int i = 0; i < 3; i++) tmr[i] = 0;
    lvl = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (tmr[j] == 0) begin
          lvl[j] = (j == 2) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
          tmr[j] = $urandom_range(1, 12);
        end else begin
          tmr[j] = tmr[j] - 1;
        end
      end
      btn_up_raw = lvl[0]; btn_down_raw = lvl[1]; btn_auto_raw = lvl[2];
      if ($urandom_range(0, 7) == 0) {sw_r_raw, sw_g_raw, sw_b_raw} = 3'($urandom);
      if (i == 1000) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_reset", {2'b0, pb_up, pb_down, mask, auto_on}, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
